shift_registers_prog: RTL

- Parametrised, programmable-length delay line for address/data words with per-word valid tracking.
- Generalises the fixed 18-bit/8-stage address shift register:
  - width and maximum depth are parameters;
  - the active delay is selectable at run time;
  - flush and emptiness status are added.
- Sits between the address generators and the memory/butterfly pipelines, matching address latency to variable-latency datapaths.

---
 rtl/newhope_sr_pkg.sv | 26 ++
 rtl/shift_tap_mux.sv | 25 ++
 rtl/shift_registers_prog.sv | 95 +++++++++
 3 files changed

// File: rtl/newhope_sr_pkg.sv
// Shared constants and helpers for the variable-latency address/data delay lines.
package newhope_sr_pkg;

  localparam int SR_WIDTH     = 18;
  localparam int SR_MAX_DEPTH = 8;

  function automatic int sr_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // A zero delay has no tap to read from, so it is promoted to one stage.
  function automatic int sr_clamp_delay(input int sel, input int max_depth);
    if (sel < 1) return 1;
    if (sel > max_depth) return max_depth;
    return sel;
  endfunction

endpackage

// File: rtl/shift_tap_mux.sv
// Output tap: picks word/valid of stage delay_q-1. Purely combinational, no backpressure.
module shift_tap_mux #(
  parameter int WIDTH     = 18,
  parameter int MAX_DEPTH = 8,
  parameter int DW        = 4
) (
  input  logic [WIDTH-1:0]     stages [MAX_DEPTH],
  input  logic [MAX_DEPTH-1:0] valids,
  input  logic [DW-1:0]        delay_q,
  output logic [WIDTH-1:0]     word,
  output logic                 valid
);

  always_comb begin
    word  = '0;
    valid = 1'b0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (delay_q == DW'(i + 1)) begin
        word  = stages[i];
        valid = valids[i];
      end
    end
  end

endmodule

// File: rtl/shift_registers_prog.sv
// Programmable-length delay line with per-word valid; latency = delay_q enabled edges.
// clken=0 freezes everything; delay changes only accepted while the line is empty.
module shift_registers_prog
  import newhope_sr_pkg::*;
#(
  parameter int WIDTH       = SR_WIDTH,
  parameter int MAX_DEPTH   = SR_MAX_DEPTH,
  parameter int RESET_DELAY = 8,
  parameter int DW          = sr_clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clken,
  input  logic             flush,
  input  logic             delay_ld,
  input  logic [DW-1:0]    delay_sel,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             empty,
  output logic [DW-1:0]    delay_cur,
  output logic             cfg_err
);

  logic [WIDTH-1:0]     stage_q [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] valid_q;
  logic [MAX_DEPTH-1:0] valid_d;
  logic                 empty_q;
  logic [DW-1:0]        delay_q;
  logic                 cfg_err_q;

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (clken) begin
      valid_d[0] = din_valid;
      for (int i = 1; i < MAX_DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_DEPTH; i++) stage_q[i] <= '0;
    end else if (!flush && clken) begin
      stage_q[0] <= din;
      for (int i = 1; i < MAX_DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // Empty covers every physical stage, so a shortened delay cannot be reloaded
  // while words still sit beyond the active tap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      empty_q <= 1'b1;
    end else begin
      valid_q <= valid_d;
      empty_q <= ~|valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      delay_q   <= DW'(RESET_DELAY);
      cfg_err_q <= 1'b0;
    end else if (delay_ld) begin
      if (empty_q) begin
        delay_q <= DW'(sr_clamp_delay(int'(delay_sel), MAX_DEPTH));
      end else begin
        cfg_err_q <= 1'b1;
      end
    end
  end

  shift_tap_mux #(
    .WIDTH     (WIDTH),
    .MAX_DEPTH (MAX_DEPTH),
    .DW        (DW)
  ) u_tap (
    .stages  (stage_q),
    .valids  (valid_q),
    .delay_q (delay_q),
    .word    (dout),
    .valid   (dout_valid)
  );

  assign empty     = empty_q;
  assign delay_cur = delay_q;
  assign cfg_err   = cfg_err_q;

endmodule
